wb_slave_mem: RTL and testbench

- Wishbone B4 classic single-port slave (responder) backed by an internal word-wide RAM.
- It is the far end of the core's Wishbone master bridge and serves as on-bus memory and a bench target for that master.
- It supports byte-lane writes, a programmable wait-state count, and cycle abort.

---
 rtl/wb_slave_mem.sv | 226 ++++++++++++++++++++++
 tb/tb_wb_slave_mem.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_mem.sv
// ---------------------------------------------------------------------------
// wb_slave_mem
//
// Wishbone B4 classic single-port slave backed by an internal word-wide RAM.
// It acts as on-bus memory and as a target for the core's Wishbone master
// bridge. It supports byte-lane writes, a fixed number of wait states, and
// abort of a cycle while waiting.
//
// Parameters:
//   DEPTH       - number of 32-bit RAM words (power of 2, >= 4)
//   BASE_ADDR   - byte address of word 0 (aligned to DEPTH*4)
//   WAIT_STATES - extra cycles inserted before termination (0..15)
//
// Ports:
//   wb_clk_i    in   1  bus clock, rising edge
//   wb_rst_n_i  in   1  asynchronous active-low reset
//   wbs_adr_i   in  32  byte address, bits [1:0] ignored
//   wbs_dat_i   in  32  write data
//   wbs_dat_o   out 32  read data, non-zero only while wbs_ack_o=1
//   wbs_we_i    in   1  1=write, 0=read
//   wbs_sel_i   in   4  byte-lane enables, bit n covers [8n+7:8n]
//   wbs_stb_i   in   1  strobe
//   wbs_cyc_i   in   1  cycle valid
//   wbs_ack_o   out  1  normal termination, one-cycle pulse
//   wbs_err_o   out  1  error termination, one-cycle pulse
//
// Handshake: a request is cyc & stb sampled in IDLE. Inputs are captured at
// that edge. The slave terminates with a single-cycle ack (or err) after
// WAIT_STATES extra cycles, then spends one dead cycle (RESP) during which
// requests are ignored, so a master that drops stb one edge after seeing
// ack is never double-counted. Dropping cyc during WAIT aborts the cycle
// with no termination and no RAM write.
//
// Optional feature macro: WB_SLAVE_MEM_ERR_EN
//   defined     - an out-of-range access terminates with err instead of ack
//   not defined - an out-of-range access terminates with ack; writes are
//                 dropped, reads return 0, wbs_err_o is constant 0
//
// Debug: the FSM state is held in state_q (type state_t) for probing.
// ---------------------------------------------------------------------------
module wb_slave_mem #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    output logic        wbs_ack_o,
    output logic        wbs_err_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES);
    localparam bit          NO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic            we_q;
    logic            hit_q;
    logic [3:0]      sel_q;
    logic [31:0]     wdat_q;
    logic [AW-1:0]   idx_q;
    logic            ack_q;
    logic            err_q;
    logic [31:0]     rdat_q;

    logic [31:0]     mem [DEPTH];

    // ---------------------------------------------------------------------
    // Address decode of the live bus inputs
    // ---------------------------------------------------------------------
    logic            req;
    logic [31:0]     off;
    logic            in_hit;
    logic [AW-1:0]   in_idx;
    logic            unused_off;

    assign req        = wbs_cyc_i & wbs_stb_i;
    assign off        = wbs_adr_i - BASE_ADDR;
    assign in_hit     = (wbs_adr_i >= BASE_ADDR) && (off[31:2] < DEPTH_W);
    assign in_idx     = off[AW+1:2];
    assign unused_off = &{1'b0, off[1:0]};

    // ---------------------------------------------------------------------
    // Termination: with no wait states the transfer completes at the same
    // edge that accepts it, so the live inputs are used; otherwise the
    // values captured at acceptance are used.
    // ---------------------------------------------------------------------
    logic            term_idle;
    logic            term_wait;
    logic            term;
    logic            t_hit;
    logic            t_we;
    logic [3:0]      t_sel;
    logic [31:0]     t_dat;
    logic [AW-1:0]   t_idx;
    logic            ram_wr;
    logic [31:0]     rdat_d;
    logic            ack_d;
    logic            err_d;

    assign term_idle = NO_WAIT && (state_q == ST_IDLE) && req;
    assign term_wait = (state_q == ST_WAIT) && wbs_cyc_i && (cnt_q == 4'd1);
    // Gating with reset keeps a pending write from landing while reset is low.
    assign term      = wb_rst_n_i && (term_idle || term_wait);

    always_comb begin
        t_hit = hit_q;
        t_we  = we_q;
        t_sel = sel_q;
        t_dat = wdat_q;
        t_idx = idx_q;
        if (state_q == ST_IDLE) begin
            t_hit = in_hit;
            t_we  = wbs_we_i;
            t_sel = wbs_sel_i;
            t_dat = wbs_dat_i;
            t_idx = in_idx;
        end
    end

    assign ram_wr = term && t_hit && t_we;

    always_comb begin
        rdat_d = 32'h0;
        if (term && t_hit && !t_we) begin
            rdat_d = mem[t_idx];
        end
    end

`ifdef WB_SLAVE_MEM_ERR_EN
    assign ack_d = term && t_hit;
    assign err_d = term && !t_hit;
`else
    assign ack_d = term;
    assign err_d = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // FSM with registered outputs. Outputs follow the termination strobe,
    // so they are high for exactly the RESP cycle and zero otherwise.
    // ---------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            hit_q   <= 1'b0;
            sel_q   <= 4'd0;
            wdat_q  <= 32'h0;
            idx_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= 32'h0;
        end else begin
            ack_q  <= ack_d;
            err_q  <= err_d;
            rdat_q <= rdat_d;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        we_q   <= wbs_we_i;
                        hit_q  <= in_hit;
                        sel_q  <= wbs_sel_i;
                        wdat_q <= wbs_dat_i;
                        idx_q  <= in_idx;
                        if (NO_WAIT) begin
                            state_q <= ST_RESP;
                        end else begin
                            cnt_q   <= WS_LOAD;
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!wbs_cyc_i) begin
                        // Master abandoned the cycle: no write, no ack.
                        cnt_q   <= 4'd0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == 4'd1) begin
                        cnt_q   <= 4'd0;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM array: contents deliberately survive reset.
    always_ff @(posedge wb_clk_i) begin
        if (ram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (t_sel[b]) begin
                    mem[t_idx][8*b +: 8] <= t_dat[8*b +: 8];
                end
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_err_o = err_q;
    assign wbs_dat_o = rdat_q;

endmodule

// File: tb/tb_wb_slave_mem.sv
module tb_wb_slave_mem;

`ifdef WB_SLAVE_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam int WS [3] = '{0, 3, 5};

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        cyc  [3];
    logic        stb  [3];
    logic        we   [3];
    logic [31:0] adr  [3];
    logic [31:0] wdat [3];
    logic [3:0]  sel  [3];
    logic [31:0] rdat [3];
    logic        ack  [3];
    logic        err  [3];

    wb_slave_mem #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbs_adr_i(adr[0]), .wbs_dat_i(wdat[0]), .wbs_dat_o(rdat[0]),
        .wbs_we_i(we[0]), .wbs_sel_i(sel[0]), .wbs_stb_i(stb[0]),
        .wbs_cyc_i(cyc[0]), .wbs_ack_o(ack[0]), .wbs_err_o(err[0])
    );
    wb_slave_mem #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbs_adr_i(adr[1]), .wbs_dat_i(wdat[1]), .wbs_dat_o(rdat[1]),
        .wbs_we_i(we[1]), .wbs_sel_i(sel[1]), .wbs_stb_i(stb[1]),
        .wbs_cyc_i(cyc[1]), .wbs_ack_o(ack[1]), .wbs_err_o(err[1])
    );
    wb_slave_mem #(.DEPTH(1024), .BASE_ADDR(32'h0), .WAIT_STATES(5)) u_dut2 (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbs_adr_i(adr[2]), .wbs_dat_i(wdat[2]), .wbs_dat_o(rdat[2]),
        .wbs_we_i(we[2]), .wbs_sel_i(sel[2]), .wbs_stb_i(stb[2]),
        .wbs_cyc_i(cyc[2]), .wbs_ack_o(ack[2]), .wbs_err_o(err[2])
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    int quiet_bad = 0;
    logic [33:0] exp_q [$];   // {err, ack, data}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [33:0] exp_term(input logic miss, input logic [31:0] d);
        logic e;
        logic a;
        e = miss && ERR_EN;
        a = !e;
        return {e, a, d};
    endfunction

    // ---------------- driver ----------------
    // Called right after a negedge; returns at the negedge after the
    // dead cycle has been checked.
    task automatic xfer(input int k, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] exp_d, input logic miss);
        int   lat;
        logic got;
        logic [33:0] e;
        exp_q.push_back(exp_term(miss, exp_d));
        cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; wdat[k] = d; sel[k] = s;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (ack[k] || err[k]) got = 1'b1;
            else if (rdat[k] != 32'h0) quiet_bad++;
        end
        cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
        e = exp_q.pop_front();
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL xfer_timeout dut=%0d adr=%h actual=no_term required=term", k, a);
        end else begin
            check($sformatf("xfer_term dut=%0d adr=%h we=%0d", k, a, w),
                  64'({err[k], ack[k], rdat[k]}), 64'(e));
            check($sformatf("latency dut=%0d", k), 64'(lat), 64'(1 + WS[k]));
            @(negedge clk);
            check($sformatf("resp_pulse dut=%0d", k),
                  64'({err[k], ack[k], rdat[k]}), 64'h0);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          k;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp_d;
        logic        miss;
    } vec_t;

    function automatic vec_t mkv(input int k, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] s,
                                 input logic [31:0] exp_d, input logic miss);
        vec_t v;
        v.k = k; v.w = w; v.a = a; v.d = d; v.s = s; v.exp_d = exp_d; v.miss = miss;
        return v;
    endfunction

    vec_t vt [19];
    logic [31:0] shadow [16];

    initial begin
        int bad;
        int nacks;
        logic [5:0] pat;
        logic [33:0] e;

        vt[0]  = mkv(0, 1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        0);
        vt[1]  = mkv(0, 0, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 0);
        vt[2]  = mkv(0, 1, 32'h20,   32'h11223344, 4'hF, 32'h0,        0);
        vt[3]  = mkv(0, 1, 32'h20,   32'hAABBCCDD, 4'h5, 32'h0,        0);
        vt[4]  = mkv(0, 0, 32'h20,   32'h0,        4'hF, 32'h11BB33DD, 0);
        vt[5]  = mkv(0, 1, 32'h24,   32'hFFFFFFFF, 4'hF, 32'h0,        0);
        vt[6]  = mkv(0, 1, 32'h24,   32'h00000000, 4'hA, 32'h0,        0);
        vt[7]  = mkv(0, 0, 32'h24,   32'h0,        4'hF, 32'h00FF00FF, 0);
        vt[8]  = mkv(0, 1, 32'h0,    32'h01020304, 4'hF, 32'h0,        0);
        vt[9]  = mkv(0, 1, 32'h1000, 32'h55555555, 4'hF, 32'h0,        1);
        vt[10] = mkv(0, 0, 32'h1000, 32'h0,        4'hF, 32'h0,        1);
        vt[11] = mkv(0, 0, 32'h0,    32'h0,        4'hF, 32'h01020304, 0);
        vt[12] = mkv(0, 1, 32'hFFC,  32'h0BADF00D, 4'hF, 32'h0,        0);
        vt[13] = mkv(0, 0, 32'hFFF,  32'h0,        4'hF, 32'h0BADF00D, 0);
        vt[14] = mkv(0, 0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 0);
        vt[15] = mkv(1, 1, 32'h0,    32'hCAFEF00D, 4'hF, 32'h0,        0);
        vt[16] = mkv(1, 0, 32'h0,    32'h0,        4'hF, 32'hCAFEF00D, 0);
        vt[17] = mkv(2, 1, 32'h8,    32'h5A5A5A5A, 4'hF, 32'h0,        0);
        vt[18] = mkv(2, 0, 32'h8,    32'h0,        4'hF, 32'h5A5A5A5A, 0);

        for (int k = 0; k < 3; k++) begin
            cyc[k] = 0; stb[k] = 0; we[k] = 0; adr[k] = 0; wdat[k] = 0; sel[k] = 0;
        end

        // reset
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++)
            check($sformatf("reset_outputs dut=%0d", k), 64'({err[k], ack[k], rdat[k]}), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // table
        for (int i = 0; i < 19; i++)
            xfer(vt[i].k, vt[i].w, vt[i].a, vt[i].d, vt[i].s, vt[i].exp_d, vt[i].miss);

        // back-to-back reads with stb held: ack every other cycle
        cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 32'h10; sel[0] = 4'hF;
        for (int i = 0; i < 3; i++) exp_q.push_back(exp_term(0, 32'hDEADBEEF));
        pat = '0;
        nacks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pat = {pat[4:0], ack[0]};
            if (ack[0] && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("b2b_data", 64'({err[0], ack[0], rdat[0]}), 64'(e));
                nacks++;
            end else if (rdat[0] != 32'h0) quiet_bad++;
        end
        cyc[0] = 0; stb[0] = 0;
        check("b2b_ack_pattern", 64'(pat), 64'(6'b101010));
        check("b2b_ack_count", 64'(nacks), 64'd3);
        exp_q.delete();
        @(negedge clk);

        // abort during WAIT (5 wait states)
        cyc[2] = 1; stb[2] = 1; we[2] = 1; adr[2] = 32'h8; wdat[2] = 32'h12345678; sel[2] = 4'hF;
        bad = 0;
        repeat (2) begin
            @(negedge clk);
            if (ack[2] || err[2]) bad++;
        end
        cyc[2] = 0; stb[2] = 0; we[2] = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack[2] || err[2]) bad++;
        end
        check("abort_no_term", 64'(bad), 64'd0);
        xfer(2, 0, 32'h8, 32'h0, 4'hF, 32'h5A5A5A5A, 0);

        // async reset: dut0 in its ack cycle, dut2 mid-WAIT with a write
        cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 32'h10; sel[0] = 4'hF;
        cyc[2] = 1; stb[2] = 1; we[2] = 1; adr[2] = 32'h8; wdat[2] = 32'h12345678; sel[2] = 4'hF;
        @(negedge clk);
        check("rst_pre_ack", 64'({ack[0], rdat[0]}), 64'({1'b1, 32'hDEADBEEF}));
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_dut0", 64'({err[0], ack[0], rdat[0]}), 64'h0);
        check("rst_async_dut2", 64'({err[2], ack[2], rdat[2]}), 64'h0);
        cyc[0] = 0; stb[0] = 0; cyc[2] = 0; stb[2] = 0; we[2] = 0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (ack[k] || err[k]) bad++;
        end
        check("rst_no_term", 64'(bad), 64'd0);
        xfer(2, 0, 32'h8,  32'h0, 4'hF, 32'h5A5A5A5A, 0);
        xfer(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0);
        xfer(1, 0, 32'h0,  32'h0, 4'hF, 32'hCAFEF00D, 0);

        // random byte-lane traffic against a shadow model
        for (int i = 0; i < 16; i++) begin
            shadow[i] = $urandom;
            xfer(0, 1, 32'h100 + 32'(4 * i), shadow[i], 4'hF, 32'h0, 0);
        end
        for (int n = 0; n < 20; n++) begin
            int          j;
            logic [3:0]  s;
            logic [31:0] d;
            j = $urandom_range(0, 15);
            s = 4'($urandom_range(0, 15));
            d = $urandom;
            xfer(0, 1, 32'h100 + 32'(4 * j), d, s, 32'h0, 0);
            for (int b = 0; b < 4; b++)
                if (s[b]) shadow[j][8*b +: 8] = d[8*b +: 8];
            xfer(0, 0, 32'h100 + 32'(4 * j), 32'h0, 4'hF, shadow[j], 0);
        end

        check("dat_quiet", 64'(quiet_bad), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
